// File: rtl/hazard_pkg.sv
// Shared constants and types for the pipeline hazard controller.
package hazard_pkg;

  localparam int unsigned NSTAGE_DEF = 10;

  localparam int unsigned STG_IFP  = 0;
  localparam int unsigned STG_IFR  = 1;
  localparam int unsigned STG_IDC  = 2;
  localparam int unsigned STG_IDR  = 3;
  localparam int unsigned STG_EXA  = 4;
  localparam int unsigned STG_EXB  = 5;
  localparam int unsigned STG_EXC  = 6;
  localparam int unsigned STG_MEMP = 7;
  localparam int unsigned STG_MEMR = 8;
  localparam int unsigned STG_WB   = 9;

  typedef logic [NSTAGE_DEF-1:0] stage_vec_t;

  localparam stage_vec_t MEM_MASK_DEF   = 10'b01_1111_1111;
  localparam stage_vec_t MALU_MASK_DEF  = 10'b00_0111_1111;
  localparam stage_vec_t FWD_MASK_DEF   = 10'b00_0000_0111;
  localparam stage_vec_t FLUSH_MASK_DEF = 10'b00_0000_1110;

  typedef enum logic {
    PEND_IDLE = 1'b0,
    PEND_WAIT = 1'b1
  } pend_state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
module sat_counter #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Mask-driven stall/flush generation with a pending-redirect
// register and saturating stall/flush counters.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned NSTAGE  = NSTAGE_DEF,
  parameter int unsigned XLEN    = 64,
  parameter int unsigned MEM_CH  = 2,
  parameter int unsigned CNT_W   = 32,
  parameter logic [NSTAGE-1:0] MEM_MASK   = MEM_MASK_DEF,
  parameter logic [NSTAGE-1:0] MALU_MASK  = MALU_MASK_DEF,
  parameter logic [NSTAGE-1:0] FWD_MASK   = FWD_MASK_DEF,
  parameter logic [NSTAGE-1:0] FLUSH_MASK = FLUSH_MASK_DEF,
  parameter int unsigned IFP_IDX = STG_IFP
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                branch_taken_i,
  input  logic [XLEN-1:0]     branch_target_i,
  input  logic                no_fwd_i,
  input  logic [2*MEM_CH-1:0] mem_state_i,
  input  logic                malu_busy_i,
  input  logic                perf_clr_i,
  output logic [NSTAGE-1:0]   stall_o,
  output logic [NSTAGE-1:0]   flush_o,
  output logic                nop_o,
  output logic                redirect_valid_o,
  output logic [XLEN-1:0]     redirect_target_o,
  output logic                pending_o,
  output logic [CNT_W-1:0]    stall_cnt_o,
  output logic [CNT_W-1:0]    flush_cnt_o
);

  if (IFP_IDX >= NSTAGE) begin : g_bad_ifp
    $error("hazard_ctrl: IFP_IDX must be below NSTAGE");
  end
  if ($bits(MEM_MASK) != NSTAGE || $bits(MALU_MASK) != NSTAGE ||
      $bits(FWD_MASK) != NSTAGE || $bits(FLUSH_MASK) != NSTAGE)
  begin : g_bad_mask
    $error("hazard_ctrl: mask widths must equal NSTAGE");
  end
  if (MEM_CH < 1) begin : g_bad_ch
    $error("hazard_ctrl: MEM_CH must be at least 1");
  end

  pend_state_e      state_q, state_d;
  logic [XLEN-1:0]  pend_tgt_q, pend_tgt_d;

  logic             mem_busy;
  logic             ifp_stall;
  logic             req_v;
  logic [XLEN-1:0]  req_tgt;
  logic [NSTAGE-1:0] stall_vec;

  assign mem_busy = |mem_state_i;

  always_comb begin
    stall_vec = ({NSTAGE{mem_busy}}    & MEM_MASK)
              | ({NSTAGE{malu_busy_i}} & MALU_MASK)
              | ({NSTAGE{no_fwd_i}}    & FWD_MASK);
  end

  assign ifp_stall = stall_vec[IFP_IDX];

  // A fresh branch is younger than any latched one, so it wins.
  assign req_v   = branch_taken_i | (state_q == PEND_WAIT);
  assign req_tgt = branch_taken_i ? branch_target_i : pend_tgt_q;

  always_comb begin
    state_d    = state_q;
    pend_tgt_d = pend_tgt_q;
    unique case (state_q)
      PEND_IDLE: begin
        if (branch_taken_i && ifp_stall) begin
          state_d    = PEND_WAIT;
          pend_tgt_d = branch_target_i;
        end
      end
      PEND_WAIT: begin
        if (ifp_stall) begin
          if (branch_taken_i) begin
            pend_tgt_d = branch_target_i;
          end
        end else begin
          state_d = PEND_IDLE;
        end
      end
      default: state_d = PEND_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= PEND_IDLE;
      pend_tgt_q <= '0;
    end else begin
      state_q    <= state_d;
      pend_tgt_q <= pend_tgt_d;
    end
  end

  assign stall_o           = stall_vec;
  assign flush_o           = req_v ? FLUSH_MASK : '0;
  assign nop_o             = no_fwd_i;
  assign redirect_valid_o  = req_v & ~ifp_stall;
  assign redirect_target_o = req_tgt;
  assign pending_o         = (state_q == PEND_WAIT);

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (ifp_stall),
    .clr   (perf_clr_i),
    .cnt_o (stall_cnt_o)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (redirect_valid_o),
    .clr   (perf_clr_i),
    .cnt_o (flush_cnt_o)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl with hand-computed vectors.
module tb_hazard_ctrl;

  localparam int unsigned NST = 10;
  localparam int unsigned XL  = 64;
  localparam int unsigned CW  = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          branch_taken_i;
  logic [XL-1:0] branch_target_i;
  logic          no_fwd_i;
  logic [3:0]    mem_state_i;
  logic          malu_busy_i;
  logic          perf_clr_i;
  logic [NST-1:0] stall_o;
  logic [NST-1:0] flush_o;
  logic          nop_o;
  logic          redirect_valid_o;
  logic [XL-1:0] redirect_target_o;
  logic          pending_o;
  logic [CW-1:0] stall_cnt_o;
  logic [CW-1:0] flush_cnt_o;

  typedef struct {
    logic [9:0]  stall;
    logic [9:0]  flush;
    logic        nop;
    logic        rv;
    logic [63:0] tgt;
    logic        pend;
    logic [3:0]  scnt;
    logic [3:0]  fcnt;
  } exp_t;

  exp_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;

  hazard_ctrl #(.CNT_W(CW)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .branch_taken_i    (branch_taken_i),
    .branch_target_i   (branch_target_i),
    .no_fwd_i          (no_fwd_i),
    .mem_state_i       (mem_state_i),
    .malu_busy_i       (malu_busy_i),
    .perf_clr_i        (perf_clr_i),
    .stall_o           (stall_o),
    .flush_o           (flush_o),
    .nop_o             (nop_o),
    .redirect_valid_o  (redirect_valid_o),
    .redirect_target_o (redirect_target_o),
    .pending_o         (pending_o),
    .stall_cnt_o       (stall_cnt_o),
    .flush_cnt_o       (flush_cnt_o)
  );

  always #5 clk = ~clk;

  function automatic exp_t mk(logic [9:0] s, logic [9:0] f, logic n,
                              logic r, logic [63:0] t, logic p,
                              logic [3:0] sc, logic [3:0] fc);
    exp_t e;
    e.stall = s; e.flush = f; e.nop = n; e.rv = r;
    e.tgt = t; e.pend = p; e.scnt = sc; e.fcnt = fc;
    return e;
  endfunction

  task automatic chk(string nm, logic [63:0] act, logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  // Monitor: outputs are sampled mid-cycle, away from the rising edge.
  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      exp_t e;
      e = sb_q.pop_front();
      chk("stall", 64'(stall_o), 64'(e.stall));
      chk("flush", 64'(flush_o), 64'(e.flush));
      chk("nop", 64'(nop_o), 64'(e.nop));
      chk("redirect_valid", 64'(redirect_valid_o), 64'(e.rv));
      if (e.flush != 10'd0)
        chk("redirect_target", redirect_target_o, e.tgt);
      chk("pending", 64'(pending_o), 64'(e.pend));
      chk("stall_cnt", 64'(stall_cnt_o), 64'(e.scnt));
      chk("flush_cnt", 64'(flush_cnt_o), 64'(e.fcnt));
    end
  end

  task automatic cyc(logic rst, logic br, logic [63:0] tgt, logic nf,
                     logic [3:0] mem, logic malu, logic clr,
                     logic do_chk, exp_t e);
    rst_n           = rst;
    branch_taken_i  = br;
    branch_target_i = tgt;
    no_fwd_i        = nf;
    mem_state_i     = mem;
    malu_busy_i     = malu;
    perf_clr_i      = clr;
    if (do_chk) sb_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  localparam logic [9:0] S_MEM  = 10'b01_1111_1111;
  localparam logic [9:0] S_MALU = 10'b00_0111_1111;
  localparam logic [9:0] S_FWD  = 10'b00_0000_0111;
  localparam logic [9:0] F_RED  = 10'b00_0000_1110;

  initial begin
    exp_t z;
    z = mk(0, 0, 0, 0, 0, 0, 0, 0);
    // Reset
    cyc(0, 0, 0, 0, 0, 0, 0, 0, z);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, z);
    cyc(0, 0, 0, 0, 0, 0, 0, 1, z);
    cyc(1, 0, 0, 0, 0, 0, 0, 1, z);
    // Memory channel 1 busy for 3 cycles
    for (int i = 0; i < 3; i++)
      cyc(1, 0, 0, 0, 4'b0100, 0, 0, 1,
          mk(S_MEM, 0, 0, 0, 0, 0, 4'(i), 0));
    cyc(1, 0, 0, 0, 0, 0, 0, 1, mk(0, 0, 0, 0, 0, 0, 3, 0));
    // Operand not forwardable
    cyc(1, 0, 0, 1, 0, 0, 0, 1, mk(S_FWD, 0, 1, 0, 0, 0, 3, 0));
    cyc(1, 0, 0, 0, 0, 0, 0, 1, mk(0, 0, 0, 0, 0, 0, 4, 0));
    // Immediate redirect
    cyc(1, 1, 64'h8000_0040, 0, 0, 0, 0, 1,
        mk(0, F_RED, 0, 1, 64'h8000_0040, 0, 4, 0));
    cyc(1, 0, 0, 0, 0, 0, 0, 1, mk(0, 0, 0, 0, 0, 0, 4, 1));
    // Branch held behind multi-cycle ALU
    cyc(1, 1, 64'h100, 0, 0, 1, 0, 1,
        mk(S_MALU, F_RED, 0, 0, 64'h100, 0, 4, 1));
    for (int i = 0; i < 3; i++)
      cyc(1, 0, 0, 0, 0, 1, 0, 1,
          mk(S_MALU, F_RED, 0, 0, 64'h100, 1, 4'(5 + i), 1));
    cyc(1, 0, 0, 0, 0, 0, 0, 1, mk(0, F_RED, 0, 1, 64'h100, 1, 8, 1));
    cyc(1, 0, 0, 0, 0, 0, 0, 1, mk(0, 0, 0, 0, 0, 0, 8, 2));
    // Younger branch overrides pending one on release
    cyc(1, 1, 64'h100, 1, 0, 0, 0, 1,
        mk(S_FWD, F_RED, 1, 0, 64'h100, 0, 8, 2));
    cyc(1, 1, 64'h200, 0, 0, 0, 0, 1,
        mk(0, F_RED, 0, 1, 64'h200, 1, 9, 2));
    cyc(1, 0, 0, 0, 0, 0, 0, 1, mk(0, 0, 0, 0, 0, 0, 9, 3));
    // Stall counter saturation, then clear
    for (int i = 0; i < 9; i++)
      cyc(1, 0, 0, 0, 4'b0001, 0, 0, 1,
          mk(S_MEM, 0, 0, 0, 0, 0, (9 + i > 15) ? 4'd15 : 4'(9 + i), 3));
    cyc(1, 0, 0, 0, 4'b0001, 0, 1, 1, mk(S_MEM, 0, 0, 0, 0, 0, 15, 3));
    cyc(1, 0, 0, 0, 0, 0, 0, 1, mk(0, 0, 0, 0, 0, 0, 0, 0));
    // Reset while a redirect is pending
    cyc(1, 1, 64'h300, 0, 0, 1, 0, 1,
        mk(S_MALU, F_RED, 0, 0, 64'h300, 0, 0, 0));
    cyc(0, 0, 0, 0, 0, 1, 0, 1,
        mk(S_MALU, F_RED, 0, 0, 64'h300, 1, 1, 0));
    cyc(1, 0, 0, 0, 0, 0, 0, 1, mk(0, 0, 0, 0, 0, 0, 0, 0));
    cyc(1, 0, 0, 0, 0, 0, 0, 0, z);
    repeat (3) @(posedge clk);
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL drain actual=%0d required=0", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
